// File: rtl/matmul_mem_engine_if.sv
// Memory port bundle for matmul_mem_engine.
// master: mem_req/mem_we/mem_addr/mem_wdata out, mem_ack/mem_rdata in.
// slave : the memory side of the same signals.
interface matmul_mem_engine_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/matmul_mem_engine.sv
// NxN signed matrix multiply engine with its own memory master:
// loads A and B, computes C=A*B (i_mode=0) or C=A*B^T (i_mode=1)
// one MAC per cycle, then stores C row-major at i_c_base.
// Ports: clk, rst (sync, active-high), i_start, i_mode, i_a_base,
// i_b_base, i_c_base, o_busy, o_done, mem (memory master modport).
// Option: define MATMUL_SAT_EN to saturate C to the signed W range
// instead of wrapping to the low W bits.
module matmul_mem_engine #(
    parameter int W  = 16,
    parameter int N  = 3,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic [AW-1:0]       i_a_base,
    input  logic [AW-1:0]       i_b_base,
    input  logic [AW-1:0]       i_c_base,
    output logic                o_busy,
    output logic                o_done,
    matmul_mem_engine_if.master mem
);
    localparam int NN   = N * N;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int IW   = (NN > 1) ? $clog2(NN) : 1;
    localparam int ACCW = 2 * W + $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_COMPUTE,
        S_STORE,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                   r_mode;
    logic [AW-1:0]          r_a_base;
    logic [AW-1:0]          r_b_base;
    logic [AW-1:0]          r_c_base;
    logic [CW-1:0]          r_i;
    logic [CW-1:0]          r_j;
    logic [CW-1:0]          r_k;
    logic signed [ACCW-1:0] r_acc;
    logic signed [W-1:0]    r_a [NN];
    logic signed [W-1:0]    r_b [NN];
    logic signed [W-1:0]    r_c [NN];
    logic                   r_req;
    logic                   r_we;
    logic [AW-1:0]          r_addr;
    logic [DW-1:0]          r_wdata;

    logic                   w_xfer;
    logic                   w_el_last;
    logic                   w_k_last;
    logic [CW-1:0]          w_ni;
    logic [CW-1:0]          w_nj;
    logic [IW-1:0]          w_idx;
    logic [IW-1:0]          w_tidx;
    logic [IW-1:0]          w_nidx;
    logic [AW-1:0]          w_noff;
    logic signed [W-1:0]    w_aik;
    logic signed [W-1:0]    w_bkj;
    logic signed [2*W-1:0]  w_prod;
    logic signed [ACCW-1:0] w_prod_x;
    logic signed [ACCW-1:0] w_acc_base;
    logic signed [ACCW-1:0] w_acc;
    logic signed [W-1:0]    w_cval;
    logic                   w_unused;

    function automatic logic [IW-1:0] idx(
        input logic [CW-1:0] r,
        input logic [CW-1:0] c
    );
        return IW'(32'(r) * N + 32'(c));
    endfunction

    assign w_xfer    = r_req & mem.mem_ack;
    assign w_el_last = (r_i == LAST) && (r_j == LAST);
    assign w_k_last  = (r_k == LAST);
    assign w_ni      = (r_j == LAST) ? CW'(r_i + 1'b1) : r_i;
    assign w_nj      = (r_j == LAST) ? '0 : CW'(r_j + 1'b1);
    assign w_idx     = idx(r_i, r_j);
    assign w_tidx    = idx(r_j, r_i);
    assign w_nidx    = idx(w_ni, w_nj);
    assign w_noff    = AW'(w_nidx) << 2;
    assign w_unused  = ^mem.mem_rdata;

    // MAC datapath: the accumulator restarts at k=0
    assign w_aik      = r_a[idx(r_i, r_k)];
    assign w_bkj      = r_b[idx(r_k, r_j)];
    assign w_prod     = w_aik * w_bkj;
    assign w_prod_x   = ACCW'(w_prod);
    assign w_acc_base = (r_k == '0) ? '0 : r_acc;
    assign w_acc      = w_acc_base + w_prod_x;

`ifdef MATMUL_SAT_EN
    logic w_ovf;
    // Fits in W bits only if all bits above W-2 equal the sign
    assign w_ovf = ~((&w_acc[ACCW-1:W-1]) | ~(|w_acc[ACCW-1:W-1]));

    always_comb begin
        w_cval = w_acc[W-1:0];
        if (w_ovf) begin
            w_cval = w_acc[ACCW-1] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign w_cval = w_acc[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_next = S_LOAD_A;
            S_LOAD_A:  if (w_xfer && w_el_last) w_next = S_LOAD_B;
            S_LOAD_B:  if (w_xfer && w_el_last) w_next = S_COMPUTE;
            S_COMPUTE: if (w_el_last && w_k_last) w_next = S_STORE;
            S_STORE:   if (w_xfer && w_el_last) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        unique case (r_state)
            S_LOAD_A, S_LOAD_B, S_COMPUTE, S_STORE: o_busy = 1'b1;
            S_FIN:   o_done = 1'b1;
            default: ;
        endcase
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            for (int e = 0; e < NN; e++) begin
                r_a[e] <= '0;
                r_b[e] <= '0;
                r_c[e] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // First A read goes out with the state change
                    if (i_start) begin
                        r_mode   <= i_mode;
                        r_a_base <= i_a_base;
                        r_b_base <= i_b_base;
                        r_c_base <= i_c_base;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_req    <= 1'b1;
                        r_we     <= 1'b0;
                        r_addr   <= i_a_base;
                    end
                end
                S_LOAD_A: begin
                    if (w_xfer) begin
                        r_a[w_idx] <= mem.mem_rdata[W-1:0];
                        if (w_el_last) begin
                            r_req <= 1'b0;
                            r_i   <= '0;
                            r_j   <= '0;
                        end else begin
                            r_i    <= w_ni;
                            r_j    <= w_nj;
                            r_addr <= r_a_base + w_noff;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (!r_req) begin
                        r_req  <= 1'b1;
                        r_addr <= r_b_base;
                    end else if (w_xfer) begin
                        r_b[r_mode ? w_tidx : w_idx] <= mem.mem_rdata[W-1:0];
                        if (w_el_last) begin
                            r_req <= 1'b0;
                            r_i   <= '0;
                            r_j   <= '0;
                        end else begin
                            r_i    <= w_ni;
                            r_j    <= w_nj;
                            r_addr <= r_b_base + w_noff;
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_acc;
                    if (w_k_last) begin
                        r_c[w_idx] <= w_cval;
                        r_k        <= '0;
                        if (w_el_last) begin
                            r_i <= '0;
                            r_j <= '0;
                        end else begin
                            r_i <= w_ni;
                            r_j <= w_nj;
                        end
                    end else begin
                        r_k <= CW'(r_k + 1'b1);
                    end
                end
                S_STORE: begin
                    if (!r_req) begin
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= r_c_base;
                        r_wdata <= DW'(r_c[w_idx]);
                    end else if (w_xfer) begin
                        if (w_el_last) begin
                            r_req <= 1'b0;
                            r_we  <= 1'b0;
                            r_i   <= '0;
                            r_j   <= '0;
                        end else begin
                            r_i     <= w_ni;
                            r_j     <= w_nj;
                            r_addr  <= r_c_base + w_noff;
                            r_wdata <= DW'(r_c[w_nidx]);
                        end
                    end
                end
                S_FIN:   ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_mem_engine.sv
// Directed bench for matmul_mem_engine (N=3, W=16) with a scoreboard
// of expected C writes and a memory model with programmable ack delay.
module tb_matmul_mem_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] a_base;
    logic [31:0] b_base;
    logic [31:0] c_base;
    logic        busy;
    logic        done;

    int n_vec     = 0;
    int n_err     = 0;
    int done_cnt  = 0;
    int rd_cnt    = 0;
    int ack_delay = 0;
    int r_wait    = 0;

    logic [63:0] sb [$];
    logic [31:0] mem [256];

    logic        p_stall = 1'b0;
    logic [31:0] p_addr  = '0;
    logic        p_we    = 1'b0;
    logic [31:0] p_wdata = '0;

    matmul_mem_engine_if #(.AW(32), .DW(32)) mif ();

    matmul_mem_engine #(
        .W (16),
        .N (3),
        .AW(32),
        .DW(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_mode  (mode),
        .i_a_base(a_base),
        .i_b_base(b_base),
        .i_c_base(c_base),
        .o_busy  (busy),
        .o_done  (done),
        .mem     (mif)
    );

    always #5 clk = ~clk;

    assign mif.mem_ack   = mif.mem_req && (r_wait >= ack_delay);
    assign mif.mem_rdata = mem[mif.mem_addr[9:2]];

    always @(posedge clk) begin
        if (rst || !mif.mem_req || mif.mem_ack) r_wait <= 0;
        else                                    r_wait <= r_wait + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: stall stability, scoreboard pops, read/done counts
    always @(negedge clk) begin
        logic [63:0] e_word;
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("hold_addr", mif.mem_addr, p_addr);
                chk("hold_we", mif.mem_we, p_we);
                chk("hold_wdata", mif.mem_wdata, p_wdata);
            end
            if (mif.mem_req && mif.mem_ack) begin
                if (mif.mem_we) begin
                    n_vec++;
                    assert (sb.size() > 0) else begin
                        n_err++;
                        $error("FAIL sb_underflow observed write %0h expected none",
                               mif.mem_addr);
                    end
                    if (sb.size() > 0) begin
                        e_word = sb.pop_front();
                        chk("c_addr", mif.mem_addr, e_word[63:32]);
                        chk("c_data", mif.mem_wdata, e_word[31:0]);
                    end
                end else begin
                    rd_cnt++;
                end
            end
            p_stall = mif.mem_req && !mif.mem_ack;
            p_addr  = mif.mem_addr;
            p_we    = mif.mem_we;
            p_wdata = mif.mem_wdata;
            if (done) done_cnt++;
        end
    end

    task automatic load(input int a[9], input int b[9],
                        input logic [31:0] ab, input logic [31:0] bb);
        for (int e = 0; e < 9; e++) begin
            mem[8'((ab >> 2) + 32'(e))] = {16'hA5A5, 16'(a[e])};
            mem[8'((bb >> 2) + 32'(e))] = {16'h5A5A, 16'(b[e])};
        end
    endtask

    task automatic expect_c(input int a[9], input int b[9],
                            input logic md, input logic [31:0] cb);
        longint      s;
        logic [15:0] c16;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += longint'(a[i*3+k]) *
                         longint'(md ? b[j*3+k] : b[k*3+j]);
                end
`ifdef MATMUL_SAT_EN
                if (s > 32767)       c16 = 16'h7FFF;
                else if (s < -32768) c16 = 16'h8000;
                else                 c16 = s[15:0];
`else
                c16 = s[15:0];
`endif
                sb.push_back({cb + 32'(4 * (i*3+j)), {{16{c16[15]}}, c16}});
            end
        end
    endtask

    task automatic kick(input logic md, input logic [31:0] ab,
                        input logic [31:0] bb, input logic [31:0] cb);
        @(negedge clk);
        mode   = md;
        a_base = ab;
        b_base = bb;
        c_base = cb;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mode   = ~md;
        a_base = '0;
        b_base = '0;
        c_base = '0;
        chk("busy_rise", busy, 1'b1);
    endtask

    task automatic wait_done(input int dly, input bit chk_lat, input int d0);
        int cyc;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (dly > 0) && (cyc == 30 || cyc == 90);
        end
        start = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        if (chk_lat) chk("latency", cyc, 56);
        @(posedge clk);
        #1;
        chk("done_pulse", done, 1'b0);
        chk("sb_drained", sb.size(), 0);
        chk("done_count", done_cnt - d0, 1);
        sb.delete();
    endtask

    initial begin
        int seq[9];
        int rev[9];
        int ident[9];
        int maxv[9];
        int neg1[9];
        int two[9];
        int d0;
        int r0;
        int n;

        seq   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        rev   = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        ident = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        for (int e = 0; e < 9; e++) begin
            maxv[e] = 32767;
            neg1[e] = -1;
            two[e]  = 2;
        end
        for (int e = 0; e < 256; e++) mem[e] = '0;

        rst    = 1'b1;
        start  = 1'b0;
        mode   = 1'b0;
        a_base = '0;
        b_base = '0;
        c_base = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_we", mif.mem_we, 1'b0);
        chk("rst_addr", mif.mem_addr, 32'h0);
        chk("rst_wdata", mif.mem_wdata, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A*B, zero-wait, latency
        ack_delay = 0;
        load(seq, rev, 32'h000, 32'h040);
        expect_c(seq, rev, 1'b0, 32'h080);
        d0 = done_cnt;
        kick(1'b0, 32'h000, 32'h040, 32'h080);
        wait_done(0, 1'b1, d0);

        // identity * B^T
        load(ident, seq, 32'h100, 32'h140);
        expect_c(ident, seq, 1'b1, 32'h180);
        d0 = done_cnt;
        kick(1'b1, 32'h100, 32'h140, 32'h180);
        wait_done(0, 1'b1, d0);

        // large positive products
        load(maxv, maxv, 32'h200, 32'h240);
        expect_c(maxv, maxv, 1'b0, 32'h280);
        d0 = done_cnt;
        kick(1'b0, 32'h200, 32'h240, 32'h280);
        wait_done(0, 1'b1, d0);

        // negative results, sign-extended write data
        load(neg1, two, 32'h300, 32'h340);
        expect_c(neg1, two, 1'b0, 32'h380);
        d0 = done_cnt;
        kick(1'b0, 32'h300, 32'h340, 32'h380);
        wait_done(0, 1'b1, d0);

        // 5-cycle ack stalls with stray start pulses
        ack_delay = 5;
        load(seq, rev, 32'h000, 32'h040);
        expect_c(seq, rev, 1'b0, 32'h0C0);
        d0 = done_cnt;
        kick(1'b0, 32'h000, 32'h040, 32'h0C0);
        wait_done(5, 1'b0, d0);

        // reset after 4 reads of B
        ack_delay = 0;
        r0 = rd_cnt;
        d0 = done_cnt;
        kick(1'b0, 32'h000, 32'h040, 32'h080);
        n = 0;
        while ((rd_cnt - r0) < 13 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reads", rd_cnt - r0, 13);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_req", mif.mem_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_addr", mif.mem_addr, 32'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);

        // fresh run with new bases after the abort
        load(ident, rev, 32'h180, 32'h1C0);
        expect_c(ident, rev, 1'b0, 32'h3C0);
        d0 = done_cnt;
        kick(1'b0, 32'h180, 32'h1C0, 32'h3C0);
        wait_done(0, 1'b1, d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
